// File: rtl/spiral_pkg.sv
// Shared types and default widths for the spiral animation sequencer.
package spiral_pkg;

    typedef enum logic [1:0] {RUN, RAMP, DRAIN, PAUSED} state_t;

    localparam int DEFAULT_OFFSET_W = 5;
    localparam int DEFAULT_SPEED_W  = 2;

    typedef logic [DEFAULT_SPEED_W-1:0] speed_t;

endpackage

// File: rtl/spiral_anim_ctrl_vsync_tick.sv
// Frame tick generation from vsync plus the palette frame counter.
// The tick is combinational in the vsync-rise cycle; frame_tick is its registered copy.
module vsync_tick #(
    parameter int PALETTE_FRAMES = 64,
    parameter int PALETTE_N      = 8
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vsync,
    input  logic                         count_en,
    output logic                         tick,
    output logic                         frame_tick,
    output logic [$clog2(PALETTE_N)-1:0] palette_idx
);

    localparam int FC_W  = (PALETTE_FRAMES > 1) ? $clog2(PALETTE_FRAMES) : 1;
    localparam int PAL_W = $clog2(PALETTE_N);

    logic            vsync_q;
    logic [FC_W-1:0] frame_cnt;

    assign tick = vsync & ~vsync_q;

    // vsync_q resets high so a vsync already asserted at release is not a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            frame_tick  <= 1'b0;
            frame_cnt   <= '0;
            palette_idx <= '0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= tick;
            if (tick && count_en) begin
                if (frame_cnt == FC_W'(PALETTE_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    palette_idx <= (palette_idx == PAL_W'(PALETTE_N - 1)) ? '0 : palette_idx + 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spiral_anim_ctrl.sv
// Frame-rate animation sequencer: phase accumulator, speed ramp, drain-to-zero reversal, pause/step.
// Optional macro SPIRAL_AUTO_REVERSE_EN adds a periodic automatic direction toggle.
module spiral_anim_ctrl
    import spiral_pkg::*;
#(
    parameter int OFFSET_W       = DEFAULT_OFFSET_W,
    parameter int SPEED_W        = DEFAULT_SPEED_W,
    parameter int RAMP_FRAMES    = 4,
    parameter int PALETTE_FRAMES = 64,
`ifdef SPIRAL_AUTO_REVERSE_EN
    parameter int REVERSE_FRAMES = 256,
`endif
    parameter int PALETTE_N      = 8
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vsync,
    input  logic [SPEED_W-1:0]           speed_target,
    input  logic                         reverse,
    input  logic                         pause_req,
    input  logic                         step,
    output logic                         pause_ack,
    output logic [3:0]                   angle_offset,
    output logic [$clog2(PALETTE_N)-1:0] palette_idx,
    output logic                         frame_tick,
    output logic                         ramping
);

    localparam int RC_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    state_t              state;
    logic [OFFSET_W-1:0] acc;
    logic [SPEED_W-1:0]  cur_speed;
    logic                dir;
    logic [RC_W-1:0]     ramp_cnt;
    logic                step_pend;

    logic                tick;
    logic                count_en;
    logic                eff_rev;
    logic                rev_mismatch;
    logic                ramp_last;
    logic [OFFSET_W-1:0] adv_amt;
    logic [OFFSET_W-1:0] acc_adv;
    logic [SPEED_W-1:0]  ramp_speed;

    assign count_en     = (state != PAUSED);
    assign angle_offset = acc[OFFSET_W-1 -: 4];

    vsync_tick #(
        .PALETTE_FRAMES (PALETTE_FRAMES),
        .PALETTE_N      (PALETTE_N)
    ) u_vsync_tick (
        .clk         (clk),
        .rst         (reset),
        .vsync       (vsync),
        .count_en    (count_en),
        .tick        (tick),
        .frame_tick  (frame_tick),
        .palette_idx (palette_idx)
    );

`ifdef SPIRAL_AUTO_REVERSE_EN
    localparam int RV_W = (REVERSE_FRAMES > 1) ? $clog2(REVERSE_FRAMES) : 1;

    logic [RV_W-1:0] rev_cnt;
    logic            auto_dir;
    logic            auto_dir_n;

    // The toggle takes effect on the very tick that completes the period.
    assign auto_dir_n = auto_dir ^ (tick && count_en && rev_cnt == RV_W'(REVERSE_FRAMES - 1));
    assign eff_rev    = reverse ^ auto_dir_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rev_cnt  <= '0;
            auto_dir <= 1'b0;
        end else if (tick && count_en) begin
            rev_cnt  <= (rev_cnt == RV_W'(REVERSE_FRAMES - 1)) ? '0 : rev_cnt + 1'b1;
            auto_dir <= auto_dir_n;
        end
    end
`else
    assign eff_rev = reverse;
`endif

    assign rev_mismatch = (eff_rev != dir);
    assign ramp_last    = (ramp_cnt == RC_W'(RAMP_FRAMES - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        adv_amt = OFFSET_W'(cur_speed);
        if (state == PAUSED && pause_req && cur_speed == '0)
            adv_amt = OFFSET_W'(1);
        acc_adv    = dir ? acc - adv_amt : acc + adv_amt;
        ramp_speed = (speed_target > cur_speed) ? cur_speed + 1'b1 : cur_speed - 1'b1;
    end

    // NOTE: state registers use non-blocking assignments only; later assignments in the block win.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            acc       <= '0;
            cur_speed <= '0;
            dir       <= 1'b0;
            ramp_cnt  <= '0;
            step_pend <= 1'b0;
            pause_ack <= 1'b0;
            ramping   <= 1'b0;
        end else begin
            if (tick) begin
                if (state != PAUSED && pause_req) begin
                    state     <= PAUSED;
                    pause_ack <= 1'b1;
                    ramping   <= 1'b0;
                end else begin
                    case (state)
                        RUN: begin
                            acc <= acc_adv;
                            if (rev_mismatch) begin
                                if (cur_speed == '0) begin
                                    dir <= ~dir;
                                end else begin
                                    state    <= DRAIN;
                                    ramping  <= 1'b1;
                                    ramp_cnt <= '0;
                                end
                            end else if (speed_target != cur_speed) begin
                                state    <= RAMP;
                                ramping  <= 1'b1;
                                ramp_cnt <= '0;
                            end
                        end
                        RAMP: begin
                            acc <= acc_adv;
                            if (rev_mismatch && cur_speed != '0) begin
                                state    <= DRAIN;
                                ramp_cnt <= '0;
                            end else begin
                                if (rev_mismatch)
                                    dir <= ~dir;
                                if (speed_target == cur_speed) begin
                                    state   <= RUN;
                                    ramping <= 1'b0;
                                end else if (ramp_last) begin
                                    cur_speed <= ramp_speed;
                                    ramp_cnt  <= '0;
                                    if (ramp_speed == speed_target) begin
                                        state   <= RUN;
                                        ramping <= 1'b0;
                                    end
                                end else begin
                                    ramp_cnt <= ramp_cnt + 1'b1;
                                end
                            end
                        end
                        DRAIN: begin
                            acc <= acc_adv;
                            if (!rev_mismatch) begin
                                state <= RAMP;
                            end else if (ramp_last) begin
                                cur_speed <= cur_speed - 1'b1;
                                ramp_cnt  <= '0;
                                if (cur_speed == SPEED_W'(1)) begin
                                    dir <= ~dir;
                                    if (speed_target != '0) begin
                                        state <= RAMP;
                                    end else begin
                                        state   <= RUN;
                                        ramping <= 1'b0;
                                    end
                                end
                            end else begin
                                ramp_cnt <= ramp_cnt + 1'b1;
                            end
                        end
                        PAUSED: begin
                            if (!pause_req) begin
                                acc       <= acc_adv;
                                pause_ack <= 1'b0;
                                step_pend <= 1'b0;
                                if (rev_mismatch && cur_speed != '0) begin
                                    state    <= DRAIN;
                                    ramping  <= 1'b1;
                                    ramp_cnt <= '0;
                                end else if (speed_target != cur_speed) begin
                                    state   <= RAMP;
                                    ramping <= 1'b1;
                                end else begin
                                    state <= RUN;
                                end
                            end else if (step_pend) begin
                                acc       <= acc_adv;
                                step_pend <= 1'b0;
                            end
                        end
                        default: state <= RUN;
                    endcase
                end
            end
            // A step arriving on the same cycle as a consuming tick stays pending.
            if (state == PAUSED && step && !(tick && !pause_req))
                step_pend <= 1'b1;
        end
    end

endmodule

// File: doc/spiral_anim_ctrl.md
Name: spiral_anim_ctrl

Overview:
Frame-rate animation sequencer for the spiral renderer. It replaces direct clocking of the angle offset on vsync with logic fully synchronous to clk. It produces the angle offset consumed by the angle/radius compare, and a palette index for colour cycling. It supports speed ramping, reversal via drain-to-zero, and pause/single-step with handshake.

Parameters:
OFFSET_W, 5, phase accumulator width; angle_offset = acc[OFFSET_W-1:OFFSET_W-4]
SPEED_W, 2, width of speed_target and internal cur_speed
RAMP_FRAMES, 4, RAMP-state frame ticks between speed steps (entry tick excluded)
PALETTE_FRAMES, 64, non-paused frames per palette step
PALETTE_N, 8, palette entries, index wraps modulo PALETTE_N
REVERSE_FRAMES, 256, auto-reverse period; only used with SPIRAL_AUTO_REVERSE_EN

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high
vsync  in  1  vsync from hvsync_generator, same clock domain
speed_target  in  SPEED_W  requested speed, sampled at frame tick
reverse  in  1  requested direction, level (1 = decrementing)
pause_req  in  1  level; pause at next frame tick
step  in  1  one-cycle pulse; single-frame advance while paused
pause_ack  out  1  high while in PAUSED
angle_offset  out  4  offset added to the CORDIC phase
palette_idx  out  $clog2(PALETTE_N)  colour scheme index
frame_tick  out  1  one-cycle pulse per frame
ramping  out  1  high in RAMP or DRAIN

Behaviour:
- Reset values: acc=0, cur_speed=0, dir=0, state=RUN, ramp_cnt=0, frame_cnt=0, palette_idx=0, step_pend=0. All outputs are 0 in reset.
- Edge detect uses vsync_q. A tick occurs in cycle N when vsync=1 and vsync_q=0.
- All tick effects are registered at the end of cycle N. frame_tick is high in cycle N+1 only, and updated acc/state are visible from N+1.
- Advance: acc += cur_speed when dir=0, acc -= cur_speed when dir=1. Width is OFFSET_W, mod 2^OFFSET_W. Each advance uses cur_speed as it was before any step on that tick.
- Tick priority: pause > reverse mismatch > speed mismatch.
- RUN:
  - Advances every tick.
  - pause_req=1 -> PAUSED, no advance that tick.
  - reverse!=dir with cur_speed=0 -> dir flips, stay RUN.
  - reverse!=dir with cur_speed!=0 -> DRAIN, ramp_cnt=0.
  - speed_target!=cur_speed -> RAMP, ramp_cnt=0.
- RAMP:
  - Advances every tick.
  - If ramp_cnt==RAMP_FRAMES-1: cur_speed moves 1 toward speed_target, ramp_cnt=0. Otherwise ramp_cnt++.
  - When cur_speed equals speed_target after the tick -> RUN.
  - Target is re-evaluated each tick. If target already equals cur_speed at a tick -> RUN with no step.
- DRAIN:
  - Same ramp timing as RAMP, but stepping toward 0 regardless of target.
  - On reaching 0: dir flips; next state is RAMP if target!=0, else RUN.
  - If reverse returns to equal dir mid-drain -> RAMP.
- PAUSED:
  - pause_ack=1. acc, cur_speed, dir and ramp_cnt are held; frame_cnt is frozen.
  - A step pulse sets step_pend.
  - At a tick with step_pend=1: one advance by max(cur_speed,1), step_pend cleared. frame_cnt does not count it.
  - At a tick with pause_req=0: resume and advance that tick. Next state is DRAIN if reverse!=dir and cur_speed!=0, else RAMP if target!=cur_speed, else RUN.
  - A step pulse outside PAUSED is ignored.
- Palette: frame_cnt increments on every non-PAUSED tick. At PALETTE_FRAMES-1 it wraps to 0 and palette_idx increments, wrapping from PALETTE_N-1 to 0.
- Asserting reset mid-frame returns everything to reset values immediately. The first tick after reset release requires a fresh 0->1 vsync edge. A vsync already high at release produces no tick, because vsync_q resets to 1.

Optional Feature:
SPIRAL_AUTO_REVERSE_EN
- Defined: a free-running counter of non-paused ticks toggles auto_dir every REVERSE_FRAMES ticks. The effective requested direction is reverse XOR auto_dir, and all reversal rules apply to it.
- Undefined: the counter and auto_dir are absent, and only the reverse port drives direction.

Decomposition:
- spiral_pkg holds:
  - state enum {RUN, RAMP, DRAIN, PAUSED};
  - default widths OFFSET_W and SPEED_W;
  - a speed typedef.
- Sub-module vsync_tick holds the vsync_q register, the tick pulse and frame_cnt/palette_idx. It takes a count-enable from the FSM.
- FSM and accumulator stay in spiral_anim_ctrl.

Test Plan:
- Ramp-up: reset, target=2, reverse=0, RAMP_FRAMES=4. Ticks 1-5 leave acc=0; speed becomes 1 at tick 5 and 2 at tick 9; acc=4 after tick 9, state RUN; acc=6 and angle_offset=3 after tick 10.
- Reverse: RUN at speed 2 with acc=20, then reverse=1. DRAIN: speed 1 at tick 4, 0 at tick 8, then dir=1 and RAMP. acc decrements only after speed rises again; ramping=1 throughout.
- Pause/step: pause_req=1 at a tick with acc=10. No advance and pause_ack=1 next cycle; acc stays 10 over 5 ticks. One step pulse gives acc=12 at the next tick (speed 2) and no further change. Dropping pause_req gives acc=14 on the resume tick.
- Palette: PALETTE_FRAMES=4, PALETTE_N=8, 33 non-paused ticks -> palette_idx = 0 (8 steps, wrap). Paused ticks do not count.
- Wrap and reset: speed 3, acc=30 -> acc=1 after one tick (mod 32). Reset asserted mid-frame with vsync high -> all outputs 0 and no tick until the next vsync rise.
- Macro: with SPIRAL_AUTO_REVERSE_EN and REVERSE_FRAMES=8, reverse held at 0 -> DRAIN begins at tick 8. Without the macro, direction never changes.
